sha256_w_sched_iter: RTL and testbench
======================================

Name: sha256_w_sched_iter

Overview:
- Iterative SHA-256 message-schedule generator. It sits directly upstream of the pipelined W-memory / compression stages.
- It accepts one 512-bit message block over a valid/ready handshake, holds it in a 16-word sliding window, and emits W_0..W_63 one word per accepted output beat.
- It also exports the live window so downstream partial-expansion stages can tap any W_{t-k}.

Parameters:
- NUM_ROUNDS, 64, number of W words emitted per block. Legal range 16..64. Counter width is fixed at 6 bits.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- in_valid  input  1  block_in is valid.
- in_ready  output  1  block accepted this cycle when in_valid && in_ready.
- block_in  input  512  message block; [511:480] = W_0 … [31:0] = W_15.
- out_valid  output  1  out_w is valid.
- out_ready  input  1  downstream accepts out_w this cycle.
- out_w  output  32  current schedule word W_t.
- out_t  output  6  round index t of out_w.
- out_last  output  1  high when out_valid && out_t == NUM_ROUNDS-1.
- window_out  output  512  live window {W_t … W_{t+15}}, with W_t in [511:480].

Behaviour:
- States:
  - IDLE: no block held.
  - RUN: block loaded, emitting.
- Reset (RST=0, asynchronous): state=IDLE, t=0, window=0. Outputs: in_ready=0 while RST=0, out_valid=0, out_w=0, out_t=0, out_last=0, window_out=0. Reset mid-block discards the block with no partial output afterwards.
- in_ready = (state==IDLE) | (state==RUN & out_last & out_ready). This is a combinational path from out_ready and permits back-to-back blocks with zero bubble.
- Load: on in_valid && in_ready, window <= block_in, t <= 0, state <= RUN. W_0 is visible on out_w the next cycle, so load-to-first-word latency is 1 cycle.
- RUN:
  - out_valid=1, out_w=window[0], out_t=t.
  - Outputs are held stable while out_ready=0 (no change to window or t).
- Advance: on out_valid && out_ready with t < NUM_ROUNDS-1:
  - window shifts left one word; new last word = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32.
  - t <= t+1.
- Function definitions:
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - All additions are 32-bit wrap-around; carries are discarded.
- Last word: on handshake with t == NUM_ROUNDS-1:
  - if in_valid is also high, load the new block (t=0, stay RUN);
  - else state <= IDLE, out_valid <= 0.
- in_valid in RUN before the last beat is ignored. The block is not accepted, and upstream must hold it.
- out_ready high in IDLE has no effect.
- window_out always reflects the internal window register, including in IDLE (last contents).

Decomposition:
- Package sha256_pkg:
  - WORD_W=32, BLOCK_W=512, NUM_W=16;
  - σ0/σ1/Σ0/Σ1 functions (shared with the compression and W-memory stages);
  - state enum {IDLE, RUN}.
- One sub-module is natural: sha256_w_expand, a purely combinational next-word computation (w0, w1, w9, w14 -> w_new). It is reused by the pipelined W-memory stages.

Test Plan:
- "abc" block (W_0=0x61626380, W_1..W_14=0, W_15=0x00000018), out_ready=1 -> out_w sequence begins 0x61626380, 0,…, then W_15=0x00000018, W_16=0x61626380, W_17=0x000F0000, W_18=0x7DA86405, W_19=0x600003C6. out_last is asserted only at out_t=63, and exactly 64 beats are emitted.
- Backpressure: toggle out_ready pseudo-randomly -> out_w/out_t are held stable during stalls, and the word sequence matches the no-stall run bit-for-bit.
- Back-to-back: a second block with in_valid held high from t=10 -> in_ready is 0 until the t=63 handshake. The second block's W_0 appears on the very next cycle, with no bubble.
- Reset mid-block: RST=0 at t=30 -> out_valid/out_w/out_t/window_out read 0 immediately (asynchronous). After release, state is IDLE with in_ready=1, and there is no residual output.
- Wrap arithmetic: block of all 0xFFFFFFFF words -> W_16 = σ1(0xFFFFFFFF)+0xFFFFFFFF+σ0(0xFFFFFFFF)+0xFFFFFFFF, mod 2^32, checked against a reference model. No X values on out_w.
- NUM_ROUNDS=16 build: "abc" block -> exactly 16 beats, out_last at out_t=15, then back to IDLE.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, sizes and bit-mixing functions.
// Used by the schedule, W-memory and compression stages.
package sha256_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int NUM_W   = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  function automatic word_t rotr(
    input word_t       x,
    input int unsigned n
  );
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t sig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational next schedule word from a 16-word window.
// w0/w1/w9/w14 are W_t, W_t+1, W_t+9, W_t+14; result is W_t+16.
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w9,
  input  logic [WORD_W-1:0] w14,
  output logic [WORD_W-1:0] w_new
);

  assign w_new = sig1(w14) + w9 + sig0(w1) + w0;

endmodule

// File: rtl/sha256_w_sched_iter.sv
// Iterative SHA-256 message schedule: one block in, W_0..W_N-1 out.
// Holds a 16-word sliding window that downstream stages may tap.
module sha256_w_sched_iter
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] block_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_w,
  output logic [5:0]         out_t,
  output logic               out_last,
  output logic [BLOCK_W-1:0] window_out
);

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

  // Element 0 sits in the top word, matching block_in layout.
  typedef logic [0:NUM_W-1][WORD_W-1:0] win_t;

  state_e            state_q, state_d;
  logic [5:0]        t_q, t_d;
  win_t              win_q, win_d;
  logic [WORD_W-1:0] w_new;
  logic              run;
  logic              at_last;
  logic              fire;
  logic              load;

  sha256_w_expand u_expand (
    .w0    (win_q[0]),
    .w1    (win_q[1]),
    .w9    (win_q[9]),
    .w14   (win_q[14]),
    .w_new (w_new)
  );

  assign run     = (state_q == RUN);
  assign at_last = run && (t_q == LAST_T);
  assign fire    = run && out_ready;
  assign load    = in_valid && in_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      t_q     <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      win_q   <= win_d;
    end
  end

  // Conditions are disjoint: load can only coincide with the last beat.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    win_d   = win_q;
    unique case (1'b1)
      load: begin
        state_d = RUN;
        t_d     = '0;
        win_d   = win_t'(block_in);
      end
      fire && !at_last: begin
        t_d   = t_q + 6'd1;
        win_d = win_t'({win_q[1:NUM_W-1], w_new});
      end
      fire && at_last && !in_valid: begin
        state_d = IDLE;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready   = RST && (!run || (at_last && out_ready));
    out_valid  = run;
    out_w      = run ? win_q[0] : '0;
    out_t      = run ? t_q : '0;
    out_last   = at_last;
    window_out = BLOCK_W'(win_q);
  end

endmodule

// File: tb/tb_sha256_w_sched_iter.sv
// Scoreboard bench for the iterative SHA-256 schedule generator.
// Expected words come from a plain array-based schedule model.
module tb_sha256_w_sched_iter;

  typedef struct {
    logic [31:0]  w;
    logic [5:0]   t;
    logic         last;
    logic [511:0] win;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] block_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_w;
  logic [5:0]   out_t;
  logic         out_last;
  logic [511:0] window_out;

  logic         in_valid16 = 1'b0;
  logic         in_ready16;
  logic [511:0] block_in16 = '0;
  logic         out_valid16;
  logic         out_ready16 = 1'b1;
  logic [31:0]  out_w16;
  logic [5:0]   out_t16;
  logic         out_last16;
  logic [511:0] window16;

  int   checks = 0;
  int   errors = 0;
  int   beats = 0;
  int   last_cnt = 0;
  bit   bp_en = 1'b0;
  exp_t q[$];

  always #5 CLK = ~CLK;

  sha256_w_sched_iter #(.NUM_ROUNDS(64)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .block_in(block_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_w(out_w), .out_t(out_t), .out_last(out_last),
    .window_out(window_out)
  );

  sha256_w_sched_iter #(.NUM_ROUNDS(16)) dut16 (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid16), .in_ready(in_ready16), .block_in(block_in16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_w(out_w16), .out_t(out_t16), .out_last(out_last16),
    .window_out(window16)
  );

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // W_0..W_78: the window at t=63 still extends 15 words beyond W_63.
  task automatic model(input logic [511:0] blk, output logic [31:0] w [0:78]);
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 79; i++)
      w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
  endtask

  task automatic push_block(input logic [511:0] blk, input int nr);
    logic [31:0] w [0:78];
    exp_t e;
    model(blk, w);
    for (int t = 0; t < nr; t++) begin
      e.w    = w[t];
      e.t    = 6'(t);
      e.last = (t == nr - 1);
      for (int k = 0; k < 16; k++) e.win[511-32*k -: 32] = w[t+k];
      q.push_back(e);
    end
  endtask

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] abc_blk();
    logic [511:0] b = '0;
    b[511:480] = 32'h61626380;
    b[31:0]    = 32'h00000018;
    return b;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom;
    return b;
  endfunction

  initial forever begin
    @(posedge CLK);
    #1;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every output handshake.
  bit          held = 1'b0;
  bit          expect_t0 = 1'b0;
  logic [31:0] hold_w;
  logic [5:0]  hold_t;

  always @(negedge CLK) begin
    if (RST)
      chk("in_ready", in_ready, !out_valid || (out_last && out_ready));
    if (out_valid) begin
      if (held) begin
        chk("stall_w", out_w, hold_w);
        chk("stall_t", out_t, hold_t);
      end
      if (expect_t0) chk("b2b_t0", out_t, 6'd0);
      expect_t0 = 1'b0;
      if (out_ready) begin
        exp_t e;
        held = 1'b0;
        beats++;
        if (out_last) last_cnt++;
        checks++;
        if ($isunknown(out_w)) begin
          errors++;
          $display("FAIL out_w_x: got %h", out_w);
        end
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got t=%0d expected no output", out_t);
        end else begin
          e = q.pop_front();
          chk("out_w", out_w, e.w);
          chk("out_t", out_t, e.t);
          chk("out_last", out_last, e.last);
          chk("window", window_out, e.win);
        end
        expect_t0 = out_last && in_valid && in_ready;
      end else begin
        held   = 1'b1;
        hold_w = out_w;
        hold_t = out_t;
      end
    end else begin
      if (expect_t0) chk("b2b_bubble", out_valid, 1'b1);
      held      = 1'b0;
      expect_t0 = 1'b0;
    end
  end

  task automatic send_block(input logic [511:0] blk);
    @(posedge CLK);
    #1;
    in_valid = 1'b1;
    block_in = blk;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (in_ready) begin
        push_block(blk, 64);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: got in_ready=0 expected 1");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLK);
      if (q.size() == 0 && !out_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
  endtask

  initial begin
    logic [31:0] w [0:78];
    logic [511:0] ones;
    bit seen;

    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_w", out_w, 32'h0);
    chk("rst_out_t", out_t, 6'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_window", window_out, 512'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    #10;
    RST = 1'b1;

    model(abc_blk(), w);
    chk("model_w16", w[16], 32'h61626380);
    chk("model_w17", w[17], 32'h000F0000);
    chk("model_w18", w[18], 32'h7DA86405);
    chk("model_w19", w[19], 32'h600003C6);

    beats = 0;
    last_cnt = 0;
    send_block(abc_blk());
    drain();
    chk("abc_beats", beats, 64);
    chk("abc_last_cnt", last_cnt, 1);

    bp_en = 1'b1;
    send_block(abc_blk());
    send_block(rand_blk());
    drain();

    bp_en = 1'b0;
    send_block(rand_blk());
    repeat (10) @(posedge CLK);
    send_block(rand_blk());
    drain();

    ones = '1;
    model(ones, w);
    chk("model_ones_w16", w[16], 32'h203FFFFC);
    send_block(ones);
    drain();

    bp_en = 1'b1;
    for (int b = 0; b < 4; b++) send_block(rand_blk());
    drain();

    send_block(rand_blk());
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge CLK);
      if (out_valid && out_t == 6'd30) seen = 1'b1;
    end
    chk("reset_reach_t30", seen, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_w", out_w, 32'h0);
    chk("mid_rst_t", out_t, 6'h0);
    chk("mid_rst_window", window_out, 512'h0);
    q.delete();
    bp_en = 1'b0;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    @(negedge CLK);
    chk("post_rst_in_ready", in_ready, 1'b1);
    repeat (3) begin
      @(negedge CLK);
      chk("post_rst_no_out", out_valid, 1'b0);
    end

    model(abc_blk(), w);
    @(posedge CLK);
    #1;
    in_valid16 = 1'b1;
    block_in16 = abc_blk();
    @(negedge CLK);
    chk("n16_in_ready", in_ready16, 1'b1);
    @(posedge CLK);
    #1;
    in_valid16 = 1'b0;
    for (int t = 0; t < 16; t++) begin
      @(negedge CLK);
      chk("n16_valid", out_valid16, 1'b1);
      chk("n16_w", out_w16, w[t]);
      chk("n16_t", out_t16, 6'(t));
      chk("n16_last", out_last16, t == 15);
    end
    @(negedge CLK);
    chk("n16_idle", out_valid16, 1'b0);
    chk("n16_idle_ready", in_ready16, 1'b1);

    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
